// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point normalise/round datapath:
// rounding-mode encodings, exponent bias and the input significand width rule.
package fp_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  // Carry + hidden + fraction + guard/round/sticky.
  function automatic int fin_w(input int man_w);
    return man_w + 5;
  endfunction

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  localparam int EXP_BIAS_DEF = exp_bias(EXP_W_DEF);

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter counted from the MSB, with an all-zero flag.
// An all-zero input reports a count of W.
module fp_lzc #(
  parameter int W     = 28,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  // Scan upward so the highest set bit is the last (winning) assignment.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) begin
        cnt = CNT_W'(W - 1 - i);
      end
    end
  end

  assign all_zero = ~|din;

endmodule

// File: rtl/fp_normalize_round_pipe.sv
// Three-stage elastic normalise-and-round pipeline: leading-one detect, shift and
// exponent adjust, then rounding, carry re-normalisation and exception flags.
module fp_normalize_round_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int FIN_W = fin_w(MAN_W),
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_in,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [FIN_W-1:0] frac_in,
  input  logic [1:0]       rnd_mode,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] man_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             overf,
  output logic             underf,
  output logic             inexact,
  output logic             zero
);

  localparam int LZ_W = $clog2(FIN_W + 1);
  localparam int EW2  = EXP_W + 2;
  localparam logic signed [EW2-1:0] E_OVF = EW2'((2 ** EXP_W) - 1);

  // ---------------- handshake ----------------
  logic v1_reg, v2_reg, v3_reg;
  logic ld2, ld3, adv1, adv2;

  assign ld3      = ~v3_reg | out_ready;
  assign adv2     = v2_reg & ld3;
  assign ld2      = ~v2_reg | adv2;
  assign adv1     = v1_reg & ld2;
  assign in_ready = ~v1_reg | adv1;

  // ---------------- S1: leading-zero count ----------------
  logic [LZ_W-1:0]  lz_next;
  logic             fzero_next;
  logic [LZ_W-1:0]  lz1_reg;
  logic             fzero1_reg;
  logic [FIN_W-1:0] frac1_reg;
  logic [EXP_W-1:0] exp1_reg;
  logic             sign1_reg;
  logic [1:0]       rm1_reg;
  logic [TAG_W-1:0] tag1_reg;

  fp_lzc #(
    .W     (FIN_W),
    .CNT_W (LZ_W)
  ) u_lzc (
    .din      (frac_in),
    .cnt      (lz_next),
    .all_zero (fzero_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_reg     <= 1'b0;
      lz1_reg    <= '0;
      fzero1_reg <= 1'b0;
      frac1_reg  <= '0;
      exp1_reg   <= '0;
      sign1_reg  <= 1'b0;
      rm1_reg    <= '0;
      tag1_reg   <= '0;
    end else if (in_ready) begin
      v1_reg <= in_valid;
      if (in_valid) begin
        lz1_reg    <= lz_next;
        fzero1_reg <= fzero_next;
        frac1_reg  <= frac_in;
        exp1_reg   <= exp_in;
        sign1_reg  <= sign_in;
        rm1_reg    <= rnd_mode;
        tag1_reg   <= tag_in;
      end
    end
  end

  // ---------------- S2: shift and exponent adjust ----------------
  // The shifted MSB is always the leading one (or zero), so it is not kept.
  logic [FIN_W-2:0]        n_next;
  logic signed [EW2-1:0]   e_next;
  logic [FIN_W-2:0]        n2_reg;
  logic signed [EW2-1:0]   e2_reg;
  logic                    fzero2_reg;
  logic                    sign2_reg;
  logic [1:0]              rm2_reg;
  logic [TAG_W-1:0]        tag2_reg;

  always_comb begin
    n_next = (FIN_W - 1)'(frac1_reg << lz1_reg);
    e_next = $signed({2'b00, exp1_reg}) + $signed(EW2'(1))
           - $signed({{(EW2 - LZ_W){1'b0}}, lz1_reg});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_reg     <= 1'b0;
      n2_reg     <= '0;
      e2_reg     <= '0;
      fzero2_reg <= 1'b0;
      sign2_reg  <= 1'b0;
      rm2_reg    <= '0;
      tag2_reg   <= '0;
    end else if (ld2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        n2_reg     <= n_next;
        e2_reg     <= e_next;
        fzero2_reg <= fzero1_reg;
        sign2_reg  <= sign1_reg;
        rm2_reg    <= rm1_reg;
        tag2_reg   <= tag1_reg;
      end
    end
  end

  // ---------------- S3: round, re-normalise, flags ----------------
  logic [MAN_W-1:0]      man_t;
  logic                  g_bit, s_bit, rup, inf_sel;
  logic [MAN_W:0]        man_sum;
  logic signed [EW2-1:0] e_r;
  logic [EXP_W-1:0]      exp_n;
  logic [MAN_W-1:0]      man_n;
  logic                  overf_n, underf_n, inexact_n, zero_n;

  always_comb begin
    man_t = n2_reg[FIN_W-2:4];
    g_bit = n2_reg[3];
    s_bit = |n2_reg[2:0];
    case (rm2_reg)
      RM_RNE:  rup = g_bit & (s_bit | man_t[0]);
      RM_RTZ:  rup = 1'b0;
      RM_RUP:  rup = ~sign2_reg & (g_bit | s_bit);
      default: rup = sign2_reg & (g_bit | s_bit);
    endcase
    // A carry out of the mantissa leaves the low bits at zero already.
    man_sum = {1'b0, man_t} + {{MAN_W{1'b0}}, rup};
    e_r     = e2_reg + $signed({{(EW2 - 1){1'b0}}, man_sum[MAN_W]});
    inf_sel = (rm2_reg == RM_RNE) | ((rm2_reg == RM_RUP) & ~sign2_reg)
            | ((rm2_reg == RM_RDN) & sign2_reg);

    exp_n     = '0;
    man_n     = '0;
    overf_n   = 1'b0;
    underf_n  = 1'b0;
    inexact_n = 1'b0;
    zero_n    = 1'b0;
    if (fzero2_reg) begin
      zero_n = 1'b1;
    end else if (e_r <= 0) begin
      underf_n  = 1'b1;
      inexact_n = 1'b1;
      zero_n    = 1'b1;
    end else if (e_r >= E_OVF) begin
      overf_n   = 1'b1;
      inexact_n = 1'b1;
      exp_n     = inf_sel ? {EXP_W{1'b1}} : {{(EXP_W - 1){1'b1}}, 1'b0};
      man_n     = inf_sel ? {MAN_W{1'b0}} : {MAN_W{1'b1}};
    end else begin
      exp_n     = e_r[EXP_W-1:0];
      man_n     = man_sum[MAN_W-1:0];
      inexact_n = g_bit | s_bit;
    end
  end

  logic             sign3_reg;
  logic [EXP_W-1:0] exp3_reg;
  logic [MAN_W-1:0] man3_reg;
  logic [TAG_W-1:0] tag3_reg;
  logic             overf3_reg, underf3_reg, inexact3_reg, zero3_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      v3_reg       <= 1'b0;
      sign3_reg    <= 1'b0;
      exp3_reg     <= '0;
      man3_reg     <= '0;
      tag3_reg     <= '0;
      overf3_reg   <= 1'b0;
      underf3_reg  <= 1'b0;
      inexact3_reg <= 1'b0;
      zero3_reg    <= 1'b0;
    end else if (ld3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        sign3_reg    <= sign2_reg;
        exp3_reg     <= exp_n;
        man3_reg     <= man_n;
        tag3_reg     <= tag2_reg;
        overf3_reg   <= overf_n;
        underf3_reg  <= underf_n;
        inexact3_reg <= inexact_n;
        zero3_reg    <= zero_n;
      end
    end
  end

  assign out_valid = v3_reg;
  assign sign_out  = sign3_reg;
  assign exp_out   = exp3_reg;
  assign man_out   = man3_reg;
  assign tag_out   = tag3_reg;
  assign overf     = overf3_reg;
  assign underf    = underf3_reg;
  assign inexact   = inexact3_reg;
  assign zero      = zero3_reg;

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Bench for fp_normalize_round_pipe: directed vector table, randomized scoreboard
// against an arithmetic reference model, back-pressure and mid-stream reset sequences.
module tb_fp_normalize_round_pipe;
  import fp_pkg::*;

  logic        clk, rst;
  logic        in_valid, in_ready, sign_in;
  logic [7:0]  exp_in;
  logic [27:0] frac_in;
  logic [1:0]  rnd_mode;
  logic [3:0]  tag_in;
  logic        out_valid, out_ready, sign_out;
  logic [7:0]  exp_out;
  logic [22:0] man_out;
  logic [3:0]  tag_out;
  logic        overf, underf, inexact, zero;

  fp_normalize_round_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .frac_in(frac_in), .rnd_mode(rnd_mode),
    .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .man_out(man_out), .tag_out(tag_out),
    .overf(overf), .underf(underf), .inexact(inexact), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] man;
    logic        overf;
    logic        underf;
    logic        inexact;
    logic        zero;
    logic [3:0]  tag;
  } res_t;

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [27:0] f;
    logic [1:0]  rm;
    res_t        exp_r;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.sign = sign_out; r.exp = exp_out; r.man = man_out;
    r.overf = overf; r.underf = underf; r.inexact = inexact; r.zero = zero;
    r.tag = tag_out;
    return r;
  endfunction

  // Reference: locate the leading one, keep 24 significant bits, round on the exact remainder.
  function automatic res_t model(logic s, logic [7:0] e_in, logic [27:0] f, logic [1:0] rm,
                                 logic [3:0] tag);
    res_t   r;
    longint e, sig, rem, half;
    int     p;
    bit     up, inf;
    r = '0; r.sign = s; r.tag = tag;
    if (f == 0) begin
      r.zero = 1'b1;
      return r;
    end
    p = 0;
    for (int i = 0; i < 28; i++) if (f[i]) p = i;
    e = longint'(e_in) - 26 + p;
    if (p >= 24) begin
      sig  = longint'(f) >> (p - 23);
      rem  = longint'(f) & ((64'sd1 << (p - 23)) - 1);
      half = 64'sd1 << (p - 24);
    end else begin
      sig  = longint'(f) << (23 - p);
      rem  = 0;
      half = 1;
    end
    case (rm)
      RM_RNE:  up = (rem > half) || (rem == half && sig[0]);
      RM_RTZ:  up = 1'b0;
      RM_RUP:  up = !s && rem != 0;
      default: up = s && rem != 0;
    endcase
    sig = sig + (up ? 1 : 0);
    if (sig == (64'sd1 << 24)) begin
      sig = 64'sd1 << 23;
      e = e + 1;
    end
    r.inexact = (rem != 0);
    if (e <= 0) begin
      r.underf = 1'b1; r.inexact = 1'b1; r.zero = 1'b1;
    end else if (e >= 255) begin
      r.overf = 1'b1; r.inexact = 1'b1;
      inf = (rm == RM_RNE) || (rm == RM_RUP && !s) || (rm == RM_RDN && s);
      r.exp = inf ? 8'hFF : 8'hFE;
      r.man = inf ? 23'h0 : 23'h7FFFFF;
    end else begin
      r.exp = 8'(e);
      r.man = 23'(sig);
    end
    return r;
  endfunction

  function automatic vec_t mkv(logic s, logic [7:0] e, logic [27:0] f, logic [1:0] rm,
                               logic [7:0] eo, logic [22:0] mo, logic [3:0] fl);
    vec_t v;
    v.s = s; v.e = e; v.f = f; v.rm = rm;
    v.exp_r = '0;
    v.exp_r.sign = s; v.exp_r.exp = eo; v.exp_r.man = mo;
    {v.exp_r.overf, v.exp_r.underf, v.exp_r.inexact, v.exp_r.zero} = fl;
    return v;
  endfunction

  task automatic drive_op(logic s, logic [7:0] e, logic [27:0] f, logic [1:0] rm, logic [3:0] t);
    sign_in = s; exp_in = e; frac_in = f; rnd_mode = rm; tag_in = t;
  endtask

  function automatic logic [27:0] rand_frac();
    logic [31:0] r, mask;
    int k;
    k = $urandom_range(0, 28);
    r = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    mask = (32'd1 << k) - 32'd1;
    return r[27:0] & mask[27:0];
  endfunction

  function automatic logic [7:0] rand_exp();
    logic [7:0] edges [6];
    edges = '{8'd0, 8'd1, 8'd2, 8'd253, 8'd254, 8'd255};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
    return 8'($urandom_range(0, 255));
  endfunction

  vec_t vecs [17];
  res_t sb [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, wt, sent, got_n, outs;
    logic s; logic [7:0] e; logic [27:0] f; logic [1:0] rm;
    res_t er;

    vecs[0]  = mkv(0, 8'd127, 28'h4000000, RM_RNE, 8'd127, 23'h0,      4'b0000);
    vecs[1]  = mkv(0, 8'd127, 28'h8000000, RM_RNE, 8'd128, 23'h0,      4'b0000);
    vecs[2]  = mkv(0, 8'd127, 28'h4000004, RM_RNE, 8'd127, 23'h0,      4'b0010);
    vecs[3]  = mkv(0, 8'd127, 28'h400000C, RM_RNE, 8'd127, 23'h2,      4'b0010);
    vecs[4]  = mkv(0, 8'd127, 28'h400000C, RM_RTZ, 8'd127, 23'h1,      4'b0010);
    vecs[5]  = mkv(0, 8'd127, 28'h7FFFFFC, RM_RNE, 8'd128, 23'h0,      4'b0010);
    vecs[6]  = mkv(0, 8'd254, 28'h8000000, RM_RNE, 8'hFF,  23'h0,      4'b1010);
    vecs[7]  = mkv(0, 8'd254, 28'h8000000, RM_RTZ, 8'hFE,  23'h7FFFFF, 4'b1010);
    vecs[8]  = mkv(1, 8'd254, 28'h8000000, RM_RUP, 8'hFE,  23'h7FFFFF, 4'b1010);
    vecs[9]  = mkv(1, 8'd254, 28'h8000000, RM_RDN, 8'hFF,  23'h0,      4'b1010);
    vecs[10] = mkv(0, 8'd1,   28'h1000000, RM_RNE, 8'd0,   23'h0,      4'b0111);
    vecs[11] = mkv(1, 8'd50,  28'h0,       RM_RNE, 8'd0,   23'h0,      4'b0001);
    vecs[12] = mkv(0, 8'd127, 28'h4000001, RM_RUP, 8'd127, 23'h1,      4'b0010);
    vecs[13] = mkv(0, 8'd127, 28'h4000001, RM_RDN, 8'd127, 23'h0,      4'b0010);
    vecs[14] = mkv(0, 8'd254, 28'h4000000, RM_RNE, 8'd254, 23'h0,      4'b0000);
    vecs[15] = mkv(0, 8'd0,   28'h4000000, RM_RNE, 8'd0,   23'h0,      4'b0111);
    vecs[16] = mkv(0, 8'd0,   28'h8000000, RM_RNE, 8'd1,   23'h0,      4'b0000);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive_op(0, 8'd0, 28'h0, RM_RNE, 4'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", 64'(dut_res()), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);

    // Directed table, one operand at a time.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      drive_op(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].rm, 4'(i));
      in_valid = 1'b1; out_ready = 1'b1;
      #1; wt = 0;
      while (!in_ready && wt < 20) begin @(negedge clk); #1; wt++; end
      @(posedge clk);
      @(negedge clk); in_valid = 1'b0; lat = 1; #1;
      while (!out_valid && lat < 20) begin @(negedge clk); #1; lat++; end
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      er = vecs[i].exp_r; er.tag = 4'(i);
      check($sformatf("vec%0d_result", i), 64'(dut_res()), 64'(er));
    end

    // Randomized stream with random back-pressure.
    sb.delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      s = 1'($urandom); e = rand_exp(); f = rand_frac(); rm = 2'($urandom);
      in_valid = ($urandom_range(0, 3) != 0);
      drive_op(s, e, f, rm, 4'(cyc));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) check("rand_unexpected_output", 64'(out_valid), 64'd0);
        else check("rand_result", 64'(dut_res()), 64'(sb.pop_front()));
      end
      if (in_valid && in_ready) sb.push_back(model(s, e, f, rm, 4'(cyc)));
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      #1;
      if (out_valid) check("drain_result", 64'(dut_res()), 64'(sb.pop_front()));
      @(negedge clk);
    end
    check("drain_empty", 64'(sb.size()), 64'd0);

    // Back-pressure: six tagged operands, consumer stalled for five cycles.
    sent = 0; got_n = 0; sb.delete();
    for (int c = 0; c < 40 && got_n < 6; c++) begin
      @(negedge clk);
      out_ready = (c >= 5);
      in_valid  = (sent < 6);
      s = 1'($urandom); e = 8'($urandom_range(20, 200)); f = rand_frac(); rm = 2'($urandom);
      drive_op(s, e, f, rm, 4'(sent));
      #1;
      if (c == 4) begin
        check("bp_accepts_before_release", 64'(sent), 64'd3);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_order%0d", got_n), 64'(tag_out), 64'(got_n));
        check($sformatf("bp_result%0d", got_n), 64'(dut_res()), 64'(sb.pop_front()));
        got_n++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(model(s, e, f, rm, 4'(sent)));
        sent++;
      end
    end
    check("bp_all_emerged", 64'(got_n), 64'd6);

    // Reset in the middle of a stream discards everything in flight.
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      drive_op(0, 8'd127, 28'h4000000, RM_RNE, 4'(c));
      in_valid = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0; #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", 64'(dut_res()), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    outs = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (out_valid) outs++;
    end
    check("midrst_no_leftovers", 64'(outs), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
